run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of monitored result channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, channel value width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 50, cycles waited after fetch_complete before declaring done (0 allowed).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100, cycle budget from reset release (>=1).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port fetch_complete  input  1  processor has fetched its last instruction.
REQ-009 SHALL have port ch_ready  input  NUM_CH  per-channel result-valid strobe; bit i is channel i.
REQ-010 SHALL have port ch_value  input  NUM_CH*DATA_W  packed values; channel i at [i*DATA_W +: DATA_W].
REQ-011 SHALL have port ch_expected  input  NUM_CH*DATA_W  golden values, same packing; used only with the check feature.
REQ-012 SHALL have port cap_value  output  NUM_CH*DATA_W  last captured value per channel.
REQ-013 SHALL have port ch_seen  output  NUM_CH  sticky, set when a channel has been captured at least once.
REQ-014 SHALL have port cycle_count  output  32  cycles elapsed in RUN+DRAIN.
REQ-015 SHALL have ports done, timed_out, pass  output  1 each  run status.
REQ-016 SHALL have port state  output  2  current FSM state.

Function
REQ-017 SHALL implement FSM states RUN=0, DRAIN=1, DONE=2, TIMEOUT=3.
REQ-018 In RUN, fetch_complete=1 SHALL move to DRAIN with drain counter cleared; with DRAIN_CYCLES=0 it SHALL move directly to DONE.
REQ-019 In DRAIN, the drain counter SHALL increment each cycle; at value DRAIN_CYCLES-1 the next state SHALL be DONE.
REQ-020 cycle_count SHALL increment by 1 each cycle in RUN or DRAIN and SHALL hold in DONE/TIMEOUT.
REQ-021 In RUN or DRAIN, cycle_count==TIMEOUT_CYCLES-1 SHALL move to TIMEOUT unless DONE is entered on the same edge; DONE wins a tie.
REQ-022 DONE and TIMEOUT SHALL be terminal until reset; fetch_complete and ch_ready SHALL be ignored there.
REQ-023 In RUN or DRAIN, ch_ready[i]=1 SHALL capture ch_value slice i into cap_value slice i and set ch_seen[i] on the same edge; the last write wins; channels are independent and simultaneous strobes are all captured.
REQ-024 A strobe on the edge that enters DONE or TIMEOUT SHALL still be captured.
REQ-025 done SHALL be 1 exactly while state==DONE; timed_out SHALL be 1 exactly while state==TIMEOUT; both registered.
REQ-026 pass SHALL be registered on the edge entering DONE and held; pass SHALL be 0 in all other states.

Reset
REQ-027 On reset: state=RUN, cycle_count=0, drain counter=0, cap_value=0, ch_seen=0, done=0, timed_out=0, pass=0.
REQ-028 Reset asserted in any state, including mid-DRAIN, SHALL restore these values on the next edge and discard all captures.

Configuration
REQ-029 Macro RUN_MONITOR_CHECK_EN defined: pass = all ch_seen bits set AND every cap_value slice equals its ch_expected slice, evaluated on the values being written on the DONE-entry edge.
REQ-030 Macro undefined: pass = all ch_seen bits set; ch_expected SHALL remain a port and be left unused.

Structure
REQ-031 Package run_monitor_pkg SHALL hold the state encoding constants and the default DRAIN_CYCLES/TIMEOUT_CYCLES values.
REQ-032 Per-channel capture, seen flag, and compare SHALL be sub-module run_monitor_chan, instantiated NUM_CH times by generate.

Verification
REQ-033 Defaults; ch_ready[0] at cycle 3 with 0x0000000A, ch_ready[1] at cycle 5 with 0x00000014, fetch_complete at cycle 10 -> done at cycle 60, cycle_count=60, ch_seen=2'b11, pass=1 (CHECK_EN with expected 0xA/0x14).
REQ-034 fetch_complete never asserted -> timed_out=1 after cycle 100, cycle_count=100, done=0, pass=0.
REQ-035 DRAIN_CYCLES=0; fetch_complete at cycle 4 -> done on the next edge, cycle_count=5.
REQ-036 ch0 written 0x1 then 0x2; expected 0x2 -> cap_value slice 0=0x2; expected 0x1 -> pass=0 with CHECK_EN, pass=1 without.
REQ-037 Reset pulsed at drain cycle 20 -> all outputs zero and state RUN on the next edge; the run then restarts normally.
REQ-038 fetch_complete timed so drain completion coincides with cycle_count==TIMEOUT_CYCLES-1 -> done=1, timed_out=0.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: state encoding and default timing values shared by
// run_monitor and its per-channel capture block.
package run_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam int unsigned DRAIN_CYCLES_DEF   = 50;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 100;

endpackage : run_monitor_pkg

// File: rtl/run_monitor_chan.sv
// run_monitor_chan: one result channel. Captures the channel value on its
// strobe while capture is enabled, keeps a sticky seen flag, and reports the
// next-cycle seen/match view so the parent can judge pass on the edge that
// ends the run (including a strobe landing on that same edge).
module run_monitor_chan #(
   parameter int unsigned DATA_W   = 32,
   parameter bit          CHECK_EN = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_en,
   input  logic              ready,
   input  logic [DATA_W-1:0] value,
   input  logic [DATA_W-1:0] expected,
   output logic [DATA_W-1:0] cap_value,
   output logic              seen,
   output logic              seen_next,
   output logic              match_next
);

   logic [DATA_W-1:0] cap_d, cap_q;
   logic              seen_d, seen_q;

   // Next capture/seen values: last strobe wins, nothing changes when disabled.
   always_comb begin
      cap_d  = cap_q;
      seen_d = seen_q;
      if (cap_en && ready) begin
         cap_d  = value;
         seen_d = 1'b1;
      end
   end

   // Without the check feature every channel reports a match, so the
   // golden value never influences pass.
   assign match_next = CHECK_EN ? (cap_d == expected) : 1'b1;
   assign seen_next  = seen_d;
   assign cap_value  = cap_q;
   assign seen       = seen_q;

   // Capture registers; a reset discards everything captured so far.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_q  <= '0;
         seen_q <= 1'b0;
      end else begin
         cap_q  <= cap_d;
         seen_q <= seen_d;
      end
   end

endmodule : run_monitor_chan

// File: rtl/run_monitor.sv
// run_monitor: watches a processor run. RUN until fetch_complete, then DRAIN
// for DRAIN_CYCLES cycles, then DONE; a cycle budget of TIMEOUT_CYCLES from
// reset release forces TIMEOUT (DONE wins a tie). Result channels are
// captured while running and pass is judged on the edge entering DONE.
// Optional feature macro: RUN_MONITOR_CHECK_EN -- when defined, pass also
// requires every captured value to equal its ch_expected slice.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_complete,
   input  logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH*DATA_W-1:0] ch_value,
   input  logic [NUM_CH*DATA_W-1:0] ch_expected,
   output logic [NUM_CH*DATA_W-1:0] cap_value,
   output logic [NUM_CH-1:0]        ch_seen,
   output logic [31:0]              cycle_count,
   output logic                     done,
   output logic                     timed_out,
   output logic                     pass,
   output logic [1:0]               state
);

`ifdef RUN_MONITOR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // Terminal counter values; the drain one is unused when DRAIN_CYCLES is 0.
   localparam logic [31:0] DRAIN_LAST   = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_e      state_d, state_q;
   logic [31:0] cycle_d, cycle_q;
   logic [31:0] drain_d, drain_q;
   logic        done_d, done_q;
   logic        timed_d, timed_q;
   logic        pass_d, pass_q;
   logic        running;

   logic [NUM_CH-1:0] seen_next;
   logic [NUM_CH-1:0] match_next;

   assign running = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      run_monitor_chan #(
         .DATA_W  (DATA_W),
         .CHECK_EN(CHECK_EN)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .cap_en    (running),
         .ready     (ch_ready[i]),
         .value     (ch_value[i*DATA_W +: DATA_W]),
         .expected  (ch_expected[i*DATA_W +: DATA_W]),
         .cap_value (cap_value[i*DATA_W +: DATA_W]),
         .seen      (ch_seen[i]),
         .seen_next (seen_next[i]),
         .match_next(match_next[i])
      );
   end

   // Next-state, counters and status; a timeout only applies when the same
   // edge does not already complete the run.
   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      drain_d = drain_q;
      pass_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (fetch_complete) begin
               drain_d = '0;
               if (DRAIN_CYCLES == 0) state_d = ST_DONE;
               else                   state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + 32'd1;
            if (drain_q == DRAIN_LAST) state_d = ST_DONE;
         end
         default: ;
      endcase
      if (running) begin
         cycle_d = cycle_q + 32'd1;
         if ((state_d != ST_DONE) && (cycle_q == TIMEOUT_LAST)) state_d = ST_TIMEOUT;
         if (state_d == ST_DONE) pass_d = (&seen_next) && (&match_next);
      end else if (state_q == ST_DONE) begin
         pass_d = pass_q;
      end
      done_d  = (state_d == ST_DONE);
      timed_d = (state_d == ST_TIMEOUT);
   end

   // FSM and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cycle_q <= '0;
         drain_q <= '0;
         done_q  <= 1'b0;
         timed_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         drain_q <= drain_d;
         done_q  <= done_d;
         timed_q <= timed_d;
         pass_q  <= pass_d;
      end
   end

   assign state       = state_q;
   assign cycle_count = cycle_q;
   assign done        = done_q;
   assign timed_out   = timed_q;
   assign pass        = pass_q;

endmodule : run_monitor

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed bench for run_monitor. One instance uses default
// parameters, a second uses DRAIN_CYCLES=0; both share the same stimulus.
// "Edge n" below is the n-th rising edge after reset release, after which
// cycle_count of a running monitor equals n.
module tb_run_monitor;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fetch_complete = 1'b0;
   logic [1:0]    ch_ready = '0;
   logic [2*DW-1:0] ch_value = '0;
   logic [2*DW-1:0] ch_expected = '0;

   logic [2*DW-1:0] cap_value, cap_value0;
   logic [1:0]    ch_seen, ch_seen0;
   logic [31:0]   cycle_count, cycle_count0;
   logic          done, done0, timed_out, timed_out0, pass, pass0;
   logic [1:0]    state, state0;

   int checks = 0;
   int errors = 0;

`ifdef RUN_MONITOR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   always #5 clk = ~clk;

   run_monitor dut (
      .clk(clk), .reset(reset), .fetch_complete(fetch_complete),
      .ch_ready(ch_ready), .ch_value(ch_value), .ch_expected(ch_expected),
      .cap_value(cap_value), .ch_seen(ch_seen), .cycle_count(cycle_count),
      .done(done), .timed_out(timed_out), .pass(pass), .state(state)
   );

   run_monitor #(.DRAIN_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .fetch_complete(fetch_complete),
      .ch_ready(ch_ready), .ch_value(ch_value), .ch_expected(ch_expected),
      .cap_value(cap_value0), .ch_seen(ch_seen0), .cycle_count(cycle_count0),
      .done(done0), .timed_out(timed_out0), .pass(pass0), .state(state0)
   );

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      fetch_complete = 1'b0;
      ch_ready = '0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", cycle_count); end
      checks++; if ({done, timed_out, pass} !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", {done, timed_out, pass}); end
      checks++; if (ch_seen !== 2'b00 || cap_value !== '0) begin errors++; $display("FAIL rst_caps seen %b cap %h exp 0", ch_seen, cap_value); end
   endtask

   task automatic test_normal_run();
      apply_reset();
      ch_expected = {32'h14, 32'hA};
      tick(2);
      ch_ready = 2'b01; ch_value[31:0] = 32'hA;
      tick(1);                                   // edge 3
      ch_ready = 2'b00;
      tick(1);
      ch_ready = 2'b10; ch_value[63:32] = 32'h14;
      tick(1);                                   // edge 5
      ch_ready = 2'b00;
      tick(4);
      fetch_complete = 1'b1;
      tick(1);                                   // edge 10
      fetch_complete = 1'b0;
      checks++; if (state !== 2'd1 || cycle_count !== 32'd10) begin errors++; $display("FAIL norm_drain state %0d count %0d exp 1/10", state, cycle_count); end
      tick(49);                                  // edge 59
      checks++; if (state !== 2'd1 || done !== 1'b0) begin errors++; $display("FAIL norm_pre_done state %0d done %b exp 1/0", state, done); end
      tick(1);                                   // edge 60
      checks++; if (done !== 1'b1 || state !== 2'd2 || timed_out !== 1'b0) begin errors++; $display("FAIL norm_done done %b state %0d to %b exp 1/2/0", done, state, timed_out); end
      checks++; if (cycle_count !== 32'd60) begin errors++; $display("FAIL norm_count got %0d exp 60", cycle_count); end
      checks++; if (ch_seen !== 2'b11 || cap_value !== {32'h14, 32'hA}) begin errors++; $display("FAIL norm_caps seen %b cap %h", ch_seen, cap_value); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL norm_pass got %b exp 1", pass); end
      // Strobes and fetch in DONE must be ignored; counters hold.
      ch_ready = 2'b01; ch_value[31:0] = 32'h99; fetch_complete = 1'b1;
      tick(1);
      ch_ready = 2'b00; fetch_complete = 1'b0;
      tick(4);
      checks++; if (cycle_count !== 32'd60 || done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL norm_hold count %0d done %b pass %b exp 60/1/1", cycle_count, done, pass); end
      checks++; if (cap_value[31:0] !== 32'hA) begin errors++; $display("FAIL norm_ignore cap0 %h exp a", cap_value[31:0]); end
   endtask

   task automatic test_timeout();
      apply_reset();
      tick(99);
      checks++; if (state !== 2'd0 || cycle_count !== 32'd99) begin errors++; $display("FAIL to_pre state %0d count %0d exp 0/99", state, cycle_count); end
      tick(1);
      checks++; if (timed_out !== 1'b1 || state !== 2'd3 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL to_flags to %b st %0d done %b pass %b exp 1/3/0/0", timed_out, state, done, pass); end
      checks++; if (cycle_count !== 32'd100) begin errors++; $display("FAIL to_count got %0d exp 100", cycle_count); end
      fetch_complete = 1'b1;
      tick(3);
      fetch_complete = 1'b0;
      checks++; if (cycle_count !== 32'd100 || state !== 2'd3) begin errors++; $display("FAIL to_hold count %0d st %0d exp 100/3", cycle_count, state); end
   endtask

   task automatic test_drain_zero();
      apply_reset();
      tick(4);
      fetch_complete = 1'b1;
      tick(1);                                   // edge 5
      fetch_complete = 1'b0;
      checks++; if (done0 !== 1'b1 || state0 !== 2'd2 || cycle_count0 !== 32'd5) begin errors++; $display("FAIL dz_done done %b st %0d count %0d exp 1/2/5", done0, state0, cycle_count0); end
      checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL dz_pass got %b exp 0", pass0); end
   endtask

   // ch0 written twice, ch1 strobed on the very edge that enters DONE.
   task automatic last_write_run(input logic [31:0] exp0);
      apply_reset();
      ch_expected = {32'h7, exp0};
      ch_ready = 2'b01; ch_value[31:0] = 32'h1;
      tick(1);
      ch_value[31:0] = 32'h2;
      tick(1);
      ch_ready = 2'b00;
      tick(1);
      ch_ready = 2'b10; ch_value[63:32] = 32'h7; fetch_complete = 1'b1;
      tick(1);                                   // edge 4: dut0 enters DONE
      ch_ready = 2'b00; fetch_complete = 1'b0;
   endtask

   task automatic test_last_write();
      last_write_run(32'h2);
      checks++; if (cap_value0 !== {32'h7, 32'h2} || ch_seen0 !== 2'b11) begin errors++; $display("FAIL lw_caps cap %h seen %b", cap_value0, ch_seen0); end
      checks++; if (done0 !== 1'b1 || pass0 !== 1'b1) begin errors++; $display("FAIL lw_pass_match done %b pass %b exp 1/1", done0, pass0); end
      last_write_run(32'h1);
      checks++; if (cap_value0[31:0] !== 32'h2) begin errors++; $display("FAIL lw_cap0 got %h exp 2", cap_value0[31:0]); end
      checks++; if (pass0 !== !CHK) begin errors++; $display("FAIL lw_pass_mism got %b exp %b", pass0, !CHK); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      tick(1);
      ch_ready = 2'b01; ch_value[31:0] = 32'h5;
      tick(1);                                   // edge 2
      ch_ready = 2'b00; fetch_complete = 1'b1;
      tick(1);                                   // edge 3: enter DRAIN
      fetch_complete = 1'b0;
      tick(20);                                  // drain counter at 20
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL md_in_drain st %0d exp 1", state); end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++; if (state !== 2'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL md_reset st %0d count %0d exp 0/0", state, cycle_count); end
      checks++; if (cap_value !== '0 || ch_seen !== 2'b00 || {done, timed_out, pass} !== 3'b000) begin errors++; $display("FAIL md_clear cap %h seen %b st %b", cap_value, ch_seen, {done, timed_out, pass}); end
      // Restart: simultaneous strobes, fetch at edge 2, done at edge 52.
      ch_expected = {32'h33, 32'h22};
      ch_ready = 2'b11; ch_value = {32'h33, 32'h22};
      tick(1);
      ch_ready = 2'b00; fetch_complete = 1'b1;
      tick(1);
      fetch_complete = 1'b0;
      tick(49);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL md_early done %b exp 0", done); end
      tick(1);
      checks++; if (done !== 1'b1 || cycle_count !== 32'd52 || pass !== 1'b1) begin errors++; $display("FAIL md_restart done %b count %0d pass %b exp 1/52/1", done, cycle_count, pass); end
      checks++; if (cap_value !== {32'h33, 32'h22} || ch_seen !== 2'b11) begin errors++; $display("FAIL md_caps cap %h seen %b", cap_value, ch_seen); end
   endtask

   task automatic test_tie();
      apply_reset();
      tick(49);
      fetch_complete = 1'b1;
      tick(1);                                   // edge 50: enter DRAIN
      fetch_complete = 1'b0;
      tick(49);                                  // edge 99
      checks++; if (state !== 2'd1 || timed_out !== 1'b0) begin errors++; $display("FAIL tie_pre st %0d to %b exp 1/0", state, timed_out); end
      tick(1);                                   // edge 100: drain ends with budget
      checks++; if (done !== 1'b1 || timed_out !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL tie_done done %b to %b st %0d exp 1/0/2", done, timed_out, state); end
      checks++; if (cycle_count !== 32'd100 || pass !== 1'b0) begin errors++; $display("FAIL tie_count count %0d pass %b exp 100/0", cycle_count, pass); end
   endtask

   initial begin
      test_reset();
      test_normal_run();
      test_timeout();
      test_drain_zero();
      test_last_write();
      test_reset_mid_drain();
      test_tie();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_run_monitor
